exception_unit: RTL and testbench

- Commit-point exception and interrupt controller; the initiator side of the CP0 write interface.
- Samples exception flags and ERET at the MEM/commit stage, prioritises them against synchronised interrupt requests, then drives CP0 update strobes (EPC, Cause, BadVAddr, EXL).
- Flushes the pipeline and issues a handshaked PC redirect to the fetch unit.

---
 rtl/cp0_pkg.sv | 18 +
 rtl/int_sync.sv | 23 ++
 rtl/exception_unit.sv | 137 +++++++++++++
 tb/tb_exception_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: MIPS ExcCode values, default exception vector and
// the exception-unit FSM state encoding.
package cp0_pkg;
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ENTER    = 2'd1;
   localparam logic [1:0] ST_ERET     = 2'd2;
   localparam logic [1:0] ST_REDIRECT = 2'd3;
endpackage

// File: rtl/int_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous interrupt lines.
module int_sync #(
   parameter int W      = 6,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [STAGES-1:0][W-1:0] pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= d;
         for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[STAGES-1];
endmodule

// File: rtl/exception_unit.sv
// Commit-point exception/interrupt controller: prioritises causes, strobes
// CP0 updates, flushes the pipe and hands a redirect PC to fetch.
module exception_unit
   import cp0_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'(EXC_VECTOR_DEFAULT),
   parameter int               SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit_valid,
   input  logic [WIDTH-1:0] commit_pc,
   input  logic             commit_bd,
   input  logic             exc_if_adel,
   input  logic             exc_ri,
   input  logic             exc_ov,
   input  logic             exc_sys,
   input  logic             exc_bp,
   input  logic             exc_mem_adel,
   input  logic             exc_mem_ades,
   input  logic [WIDTH-1:0] mem_vaddr,
   input  logic             commit_eret,
   input  logic [5:0]       hw_int,
   input  logic [1:0]       sw_int,
   input  logic [7:0]       status_im,
   input  logic             status_exl,
   input  logic             status_ie,
   input  logic [WIDTH-1:0] cp0_epc,
   input  logic             redirect_ready,
   output logic             cp0_exc_we,
   output logic [4:0]       cp0_exc_code,
   output logic [WIDTH-1:0] cp0_epc_out,
   output logic             cp0_bd,
   output logic             cp0_badvaddr_we,
   output logic [WIDTH-1:0] cp0_badvaddr,
   output logic             cp0_clr_exl,
   output logic             int_pending,
   output logic             flush,
   output logic             redirect_valid,
   output logic [WIDTH-1:0] redirect_pc
);
   logic [1:0]       state;
   logic [5:0]       hw_sync;
   logic [7:0]       ip;
   logic             take;
   logic [4:0]       code;
   logic             bv_we;
   logic [WIDTH-1:0] bv;
   logic             bv_we_q;

   int_sync #(.W(6), .STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (hw_int),
      .q   (hw_sync)
   );

   assign ip          = {hw_sync, sw_int};
   assign int_pending = (|(ip & status_im)) & status_ie & ~status_exl;

   // Interrupt outranks every synchronous cause; only address errors load BadVAddr.
   always_comb begin
      take  = 1'b1;
      code  = EXC_INT;
      bv_we = 1'b0;
      bv    = commit_pc;
      if (int_pending) begin
         code = EXC_INT;
      end else if (exc_if_adel) begin
         code  = EXC_ADEL;
         bv_we = 1'b1;
      end else if (exc_ri) begin
         code = EXC_RI;
      end else if (exc_ov) begin
         code = EXC_OV;
      end else if (exc_sys) begin
         code = EXC_SYS;
      end else if (exc_bp) begin
         code = EXC_BP;
      end else if (exc_mem_adel) begin
         code  = EXC_ADEL;
         bv_we = 1'b1;
         bv    = mem_vaddr;
      end else if (exc_mem_ades) begin
         code  = EXC_ADES;
         bv_we = 1'b1;
         bv    = mem_vaddr;
      end else begin
         take = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cp0_exc_code <= '0;
         cp0_epc_out  <= '0;
         cp0_bd       <= 1'b0;
         cp0_badvaddr <= '0;
         bv_we_q      <= 1'b0;
         redirect_pc  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (commit_valid && take) begin
                  state        <= ST_ENTER;
                  cp0_exc_code <= code;
                  cp0_epc_out  <= commit_bd ? commit_pc - WIDTH'(4) : commit_pc;
                  cp0_bd       <= commit_bd;
                  cp0_badvaddr <= bv;
                  bv_we_q      <= bv_we;
               end else if (commit_valid && commit_eret) begin
                  state <= ST_ERET;
               end
            end
            ST_ENTER: begin
               state       <= ST_REDIRECT;
               redirect_pc <= EXC_VECTOR;
            end
            ST_ERET: begin
               state       <= ST_REDIRECT;
               redirect_pc <= cp0_epc;
            end
            default: begin
               if (redirect_ready) state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cp0_exc_we      = (state == ST_ENTER);
   assign cp0_badvaddr_we = (state == ST_ENTER) & bv_we_q;
   assign cp0_clr_exl     = (state == ST_ERET);
   assign redirect_valid  = (state == ST_REDIRECT);
   assign flush           = (state != ST_IDLE);
endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: each task drives one scenario and checks inline.
module tb_exception_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid, commit_bd, commit_eret;
   logic [31:0] commit_pc, mem_vaddr, cp0_epc;
   logic        exc_if_adel, exc_ri, exc_ov, exc_sys, exc_bp, exc_mem_adel, exc_mem_ades;
   logic [5:0]  hw_int;
   logic [1:0]  sw_int;
   logic [7:0]  status_im;
   logic        status_exl, status_ie, redirect_ready;
   logic        cp0_exc_we, cp0_bd, cp0_badvaddr_we, cp0_clr_exl, int_pending, flush, redirect_valid;
   logic [4:0]  cp0_exc_code;
   logic [31:0] cp0_epc_out, cp0_badvaddr, redirect_pc;
   logic [4:0]  strb;

   int checks   = 0;
   int failures = 0;

   exception_unit dut (
      .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_bd(commit_bd), .exc_if_adel(exc_if_adel), .exc_ri(exc_ri), .exc_ov(exc_ov),
      .exc_sys(exc_sys), .exc_bp(exc_bp), .exc_mem_adel(exc_mem_adel),
      .exc_mem_ades(exc_mem_ades), .mem_vaddr(mem_vaddr), .commit_eret(commit_eret),
      .hw_int(hw_int), .sw_int(sw_int), .status_im(status_im), .status_exl(status_exl),
      .status_ie(status_ie), .cp0_epc(cp0_epc), .redirect_ready(redirect_ready),
      .cp0_exc_we(cp0_exc_we), .cp0_exc_code(cp0_exc_code), .cp0_epc_out(cp0_epc_out),
      .cp0_bd(cp0_bd), .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr),
      .cp0_clr_exl(cp0_clr_exl), .int_pending(int_pending), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;
   // {exc_we, clr_exl, flush, redirect_valid, badvaddr_we}
   assign strb = {cp0_exc_we, cp0_clr_exl, flush, redirect_valid, cp0_badvaddr_we};

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_commit();
      commit_valid = 0; commit_bd = 0; commit_eret = 0; commit_pc = '0; mem_vaddr = '0;
      exc_if_adel = 0; exc_ri = 0; exc_ov = 0; exc_sys = 0; exc_bp = 0;
      exc_mem_adel = 0; exc_mem_ades = 0;
   endtask

   task automatic test_reset();
      clear_commit();
      hw_int = '0; sw_int = '0; status_im = '0; status_exl = 0; status_ie = 0;
      cp0_epc = '0; redirect_ready = 0;
      rst = 1;
      step(); step();
      checks++;
      if (strb !== 5'b0) begin
         $display("FAIL reset_strobes got=%b want=00000", strb); failures++;
      end
      checks++;
      if ({cp0_exc_code, cp0_epc_out, cp0_badvaddr, redirect_pc, int_pending} !== '0) begin
         $display("FAIL reset_values code=%h epc=%h bva=%h rpc=%h ip=%b",
                  cp0_exc_code, cp0_epc_out, cp0_badvaddr, redirect_pc, int_pending);
         failures++;
      end
      rst = 0;
      step();
   endtask

   task automatic test_syscall();
      commit_valid = 1; commit_pc = 32'h80001000; exc_sys = 1;
      step(); clear_commit();
      checks++;
      if (strb !== 5'b10100) begin
         $display("FAIL sys_enter_strobes got=%b want=10100", strb); failures++;
      end
      checks++;
      if ({cp0_exc_code, cp0_epc_out, cp0_bd} !== {5'd8, 32'h80001000, 1'b0}) begin
         $display("FAIL sys_capture code=%0d epc=%h bd=%b want 8 80001000 0",
                  cp0_exc_code, cp0_epc_out, cp0_bd);
         failures++;
      end
      step();
      checks++;
      if (strb !== 5'b00110 || redirect_pc !== 32'hBFC00380) begin
         $display("FAIL sys_redirect strobes=%b pc=%h want 00110 bfc00380", strb, redirect_pc);
         failures++;
      end
      redirect_ready = 1;
      step(); redirect_ready = 0;
      checks++;
      if (strb !== 5'b00000) begin
         $display("FAIL sys_idle got=%b want=00000", strb); failures++;
      end
   endtask

   task automatic test_delay_slot_adel();
      commit_valid = 1; commit_pc = 32'h80002004; commit_bd = 1; exc_mem_adel = 1;
      mem_vaddr = 32'h00000003;
      step(); clear_commit();
      checks++;
      if (strb !== 5'b10101) begin
         $display("FAIL adel_strobes got=%b want=10101", strb); failures++;
      end
      checks++;
      if ({cp0_exc_code, cp0_epc_out, cp0_bd, cp0_badvaddr} !==
          {5'd4, 32'h80002000, 1'b1, 32'h00000003}) begin
         $display("FAIL adel_capture code=%0d epc=%h bd=%b bva=%h want 4 80002000 1 00000003",
                  cp0_exc_code, cp0_epc_out, cp0_bd, cp0_badvaddr);
         failures++;
      end
      step(); redirect_ready = 1; step(); redirect_ready = 0;
   endtask

   task automatic test_causes();
      // fetch AdEL beats RI; BadVAddr takes commit_pc
      commit_valid = 1; commit_pc = 32'h00000402; exc_if_adel = 1; exc_ri = 1;
      mem_vaddr = 32'h12345678;
      step(); clear_commit();
      checks++;
      if ({cp0_exc_code, cp0_badvaddr_we, cp0_badvaddr} !== {5'd4, 1'b1, 32'h00000402}) begin
         $display("FAIL if_adel code=%0d we=%b bva=%h want 4 1 00000402",
                  cp0_exc_code, cp0_badvaddr_we, cp0_badvaddr);
         failures++;
      end
      step(); redirect_ready = 1; step(); redirect_ready = 0;
      // RI beats OV, SYS, BP, AdES
      commit_valid = 1; commit_pc = 32'h80000010; exc_ri = 1; exc_ov = 1; exc_sys = 1;
      exc_bp = 1; exc_mem_ades = 1;
      step(); clear_commit();
      checks++;
      if ({cp0_exc_code, cp0_badvaddr_we} !== {5'd10, 1'b0}) begin
         $display("FAIL ri_prio code=%0d we=%b want 10 0", cp0_exc_code, cp0_badvaddr_we);
         failures++;
      end
      step(); redirect_ready = 1; step(); redirect_ready = 0;
      // BP beats AdES
      commit_valid = 1; commit_pc = 32'h80000020; exc_bp = 1; exc_mem_ades = 1;
      step(); clear_commit();
      checks++;
      if ({cp0_exc_code, cp0_badvaddr_we} !== {5'd9, 1'b0}) begin
         $display("FAIL bp_prio code=%0d we=%b want 9 0", cp0_exc_code, cp0_badvaddr_we);
         failures++;
      end
      step(); redirect_ready = 1; step(); redirect_ready = 0;
      // AdES alone
      commit_valid = 1; commit_pc = 32'h80000030; exc_mem_ades = 1; mem_vaddr = 32'h10000006;
      step(); clear_commit();
      checks++;
      if ({cp0_exc_code, cp0_badvaddr_we, cp0_badvaddr} !== {5'd5, 1'b1, 32'h10000006}) begin
         $display("FAIL ades code=%0d we=%b bva=%h want 5 1 10000006",
                  cp0_exc_code, cp0_badvaddr_we, cp0_badvaddr);
         failures++;
      end
      step(); redirect_ready = 1; step(); redirect_ready = 0;
   endtask

   task automatic test_interrupt();
      status_im = 8'h04; status_ie = 1; status_exl = 0;
      hw_int = 6'b000001;
      step();
      checks++;
      if (int_pending !== 1'b0) begin
         $display("FAIL int_sync_one got=%b want=0", int_pending); failures++;
      end
      step();
      checks++;
      if (int_pending !== 1'b1) begin
         $display("FAIL int_sync_two got=%b want=1", int_pending); failures++;
      end
      commit_valid = 1; commit_pc = 32'h80004000; exc_ov = 1;
      step(); clear_commit();
      checks++;
      if ({cp0_exc_we, cp0_exc_code, cp0_badvaddr_we} !== {1'b1, 5'd0, 1'b0}) begin
         $display("FAIL int_wins we=%b code=%0d bvwe=%b want 1 0 0",
                  cp0_exc_we, cp0_exc_code, cp0_badvaddr_we);
         failures++;
      end
      step(); redirect_ready = 1; step(); redirect_ready = 0;
      status_exl = 1;
      #1;
      checks++;
      if (int_pending !== 1'b0) begin
         $display("FAIL int_exl_mask got=%b want=0", int_pending); failures++;
      end
      commit_valid = 1; commit_pc = 32'h80004000; exc_ov = 1;
      step(); clear_commit();
      checks++;
      if ({cp0_exc_we, cp0_exc_code} !== {1'b1, 5'd12}) begin
         $display("FAIL exl_ov we=%b code=%0d want 1 12", cp0_exc_we, cp0_exc_code);
         failures++;
      end
      step(); redirect_ready = 1; step(); redirect_ready = 0;
      status_exl = 0; status_ie = 0; hw_int = '0; status_im = '0;
      step(); step();
   endtask

   task automatic test_eret();
      commit_valid = 1; commit_eret = 1; cp0_epc = 32'h80003000; commit_pc = 32'h80005000;
      step(); clear_commit();
      checks++;
      if (strb !== 5'b01100) begin
         $display("FAIL eret_strobes got=%b want=01100", strb); failures++;
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (strb !== 5'b00110 || redirect_pc !== 32'h80003000) begin
            $display("FAIL eret_hold%0d strobes=%b pc=%h want 00110 80003000", i, strb, redirect_pc);
            failures++;
         end
         cp0_epc = 32'hDEAD0000;
      end
      redirect_ready = 1; step(); redirect_ready = 0;
      checks++;
      if (strb !== 5'b00000) begin
         $display("FAIL eret_idle got=%b want=00000", strb); failures++;
      end
   endtask

   task automatic test_back_to_back();
      commit_valid = 1; commit_pc = 32'h80006000; exc_sys = 1;
      step();
      exc_sys = 0; exc_ri = 1; commit_pc = 32'h80006004;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (strb !== 5'b00110) begin
            $display("FAIL ignore%0d strobes=%b want=00110", i, strb); failures++;
         end
      end
      redirect_ready = 1; commit_valid = 0; exc_ri = 0;
      step(); redirect_ready = 0;
      commit_valid = 1; commit_pc = 32'h80006008; exc_bp = 1;
      step(); clear_commit();
      checks++;
      if ({cp0_exc_we, cp0_exc_code, cp0_epc_out} !== {1'b1, 5'd9, 32'h80006008}) begin
         $display("FAIL b2b we=%b code=%0d epc=%h want 1 9 80006008",
                  cp0_exc_we, cp0_exc_code, cp0_epc_out);
         failures++;
      end
      step(); redirect_ready = 1; step(); redirect_ready = 0;
   endtask

   task automatic test_async_reset();
      commit_valid = 1; commit_pc = 32'h80007000; exc_ov = 1;
      step(); clear_commit();
      step();
      checks++;
      if (redirect_valid !== 1'b1) begin
         $display("FAIL arst_setup rv=%b want=1", redirect_valid); failures++;
      end
      #2 rst = 1;
      #1;
      checks++;
      if ({strb, cp0_exc_code, cp0_epc_out, redirect_pc} !== '0) begin
         $display("FAIL arst_immediate strobes=%b code=%0d epc=%h rpc=%h want all 0",
                  strb, cp0_exc_code, cp0_epc_out, redirect_pc);
         failures++;
      end
      step();
      rst = 0;
      redirect_ready = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (strb !== 5'b00000) begin
            $display("FAIL arst_after%0d strobes=%b want=00000", i, strb); failures++;
         end
      end
      redirect_ready = 0;
   endtask

   initial begin
      test_reset();
      test_syscall();
      test_delay_slot_adel();
      test_causes();
      test_interrupt();
      test_eret();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
